// File: rtl/collector_if.sv
// Scanner-to-collector result bus and collector record output port.
// slave is the collector's view, master the driving/consuming side.
interface collector_if;
  logic         scn_dvld_clt;
  logic [7:0]   scn_cmd_clt;
  logic [23:0]  scn_id_clt;
  logic [255:0] scn_data_clt;
  logic [31:0]  scn_bvld_clt;
  logic         scn_end_clt;
  logic         clt_rdy_scn;
  logic         clt_dvld_out;
  logic [127:0] clt_rec_out;
  logic         clt_rdy_in;

  modport slave (
    input  scn_dvld_clt, scn_cmd_clt, scn_id_clt, scn_data_clt, scn_bvld_clt,
           scn_end_clt, clt_rdy_in,
    output clt_rdy_scn, clt_dvld_out, clt_rec_out
  );

  modport master (
    output scn_dvld_clt, scn_cmd_clt, scn_id_clt, scn_data_clt, scn_bvld_clt,
           scn_end_clt, clt_rdy_in,
    input  clt_rdy_scn, clt_dvld_out, clt_rec_out
  );
endinterface

// File: rtl/collector.sv
// Result collector: turns scanner hit beats into 128-bit match records queued
// in a first-word-fall-through FIFO, with block/hit/miss stats and a sticky error.
module collector #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int KEEP_MISS = 0
) (
  input  logic        clk,
  input  logic        reset,
  collector_if.slave  bus,
  output logic [31:0] clt_blk_cnt,
  output logic [31:0] clt_hit_cnt,
  output logic [31:0] clt_miss_cnt,
  output logic        clt_err
);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_FULL} state_e;

  state_e         state_q, state_d;
  logic [AW:0]    occ_q, occ_d;
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [31:0]    seq_q, blk_q, hit_q, miss_q;
  logic           err_q;
  logic [127:0]   mem_q [DEPTH];

  logic [31:0]    sig_cnt, sig_id, sig_off;
  logic           accept, is_hit, push, pop, bad_beat;
  logic [127:0]   rec_in;

  assign sig_cnt = bus.scn_data_clt[31:0];
  assign sig_id  = bus.scn_data_clt[63:32];
  assign sig_off = bus.scn_data_clt[95:64];

  // Ready/valid come straight from the registered state, so a same-cycle pop
  // never opens a full FIFO.
  assign bus.clt_rdy_scn  = ~reset & (state_q != S_FULL);
  assign bus.clt_dvld_out = (state_q != S_EMPTY);
  assign bus.clt_rec_out  = mem_q[rptr_q];

  assign accept   = bus.scn_dvld_clt & bus.clt_rdy_scn;
  assign is_hit   = (sig_cnt != 32'd0);
  assign push     = accept & (is_hit | (KEEP_MISS != 0));
  assign pop      = bus.clt_dvld_out & bus.clt_rdy_in;
  assign bad_beat = (bus.scn_bvld_clt != 32'hFFFF_FFFF) | ~bus.scn_end_clt |
                    (bus.scn_data_clt[255:96] != '0);
  assign rec_in   = {bus.scn_cmd_clt, bus.scn_id_clt, sig_id, sig_off, seq_q};

  assign clt_blk_cnt  = blk_q;
  assign clt_hit_cnt  = hit_q;
  assign clt_miss_cnt = miss_q;
  assign clt_err      = err_q;

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY:  if (push) state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (occ_d == FULL_OCC)   state_d = S_FULL;
        else if (occ_d == '0)    state_d = S_EMPTY;
      end
      S_FULL:   if (pop) state_d = S_ACTIVE;
      default:  state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
      occ_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      seq_q   <= '0;
      blk_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
        seq_q  <= seq_q + 32'd1;
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      if (accept) begin
        if (bus.scn_end_clt) blk_q <= blk_q + 32'd1;
        if (is_hit) hit_q  <= hit_q + 32'd1;
        else        miss_q <= miss_q + 32'd1;
        if (bad_beat) err_q <= 1'b1;
      end
    end
  end

  // Storage carries no reset; contents are only observed while occupied.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= rec_in;
  end
endmodule

// File: tb/tb_collector.sv
// Randomized bench for collector: DUT0 drops misses, DUT1 keeps them; both are
// checked every cycle against a queue-based reference model.
module tb_collector;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]   cmd;
  logic [23:0]  id;
  logic [255:0] data;
  logic [31:0]  bvld;
  logic         endb, dv0, dv1, rdy_in;
  logic [31:0]  blk0, hit0, miss0, blk1, hit1, miss1;
  logic         err0, err1;

  collector_if ifa();
  collector_if ifb();

  assign ifa.scn_dvld_clt = dv0;
  assign ifa.scn_cmd_clt  = cmd;
  assign ifa.scn_id_clt   = id;
  assign ifa.scn_data_clt = data;
  assign ifa.scn_bvld_clt = bvld;
  assign ifa.scn_end_clt  = endb;
  assign ifa.clt_rdy_in   = rdy_in;
  assign ifb.scn_dvld_clt = dv1;
  assign ifb.scn_cmd_clt  = cmd;
  assign ifb.scn_id_clt   = id;
  assign ifb.scn_data_clt = data;
  assign ifb.scn_bvld_clt = bvld;
  assign ifb.scn_end_clt  = endb;
  assign ifb.clt_rdy_in   = rdy_in;

  collector #(.DEPTH(16), .AW(4), .KEEP_MISS(0)) u0 (
    .clk(clk), .reset(reset), .bus(ifa), .clt_blk_cnt(blk0),
    .clt_hit_cnt(hit0), .clt_miss_cnt(miss0), .clt_err(err0));
  collector #(.DEPTH(16), .AW(4), .KEEP_MISS(1)) u1 (
    .clk(clk), .reset(reset), .bus(ifb), .clt_blk_cnt(blk1),
    .clt_hit_cnt(hit1), .clt_miss_cnt(miss1), .clt_err(err1));

  // reference model
  logic [127:0] mq0[$];
  logic [127:0] mq1[$];
  logic [31:0]  m_seq[2], m_blk[2], m_hit[2], m_miss[2];
  logic         m_err[2];
  logic         acc[2];
  int n_chk = 0;
  int n_fail = 0;

  task automatic model_clear();
    mq0.delete();
    mq1.delete();
    for (int k = 0; k < 2; k++) begin
      m_seq[k] = 0; m_blk[k] = 0; m_hit[k] = 0; m_miss[k] = 0; m_err[k] = 0;
      acc[k] = 0;
    end
  endtask

  task automatic set_beat(input logic hitb);
    cmd  = 8'($urandom);
    id   = 24'($urandom);
    data = '0;
    data[31:0]  = hitb ? 32'($urandom_range(1, 9)) : 32'd0;
    data[63:32] = $urandom;
    data[95:64] = $urandom;
    bvld = 32'hFFFF_FFFF;
    endb = 1'b1;
  endtask

  // Called at a negedge with inputs set: checks outputs, advances one edge.
  task automatic step();
    logic r[2], v[2], e[2], dv[2], hitb, bad;
    logic [127:0] rec[2], expv;
    logic [31:0] b[2], h[2], m[2];
    int sz[2];
    #1;
    r[0] = ifa.clt_rdy_scn;  r[1] = ifb.clt_rdy_scn;
    v[0] = ifa.clt_dvld_out; v[1] = ifb.clt_dvld_out;
    rec[0] = ifa.clt_rec_out; rec[1] = ifb.clt_rec_out;
    b[0] = blk0; b[1] = blk1; h[0] = hit0; h[1] = hit1;
    m[0] = miss0; m[1] = miss1; e[0] = err0; e[1] = err1;
    sz[0] = mq0.size(); sz[1] = mq1.size();
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (r[k] !== (sz[k] < DEPTH)) begin
        n_fail++; $display("FAIL rdy_scn dut%0d: got %b exp %b", k, r[k], sz[k] < DEPTH);
      end
      n_chk++;
      if (v[k] !== (sz[k] != 0)) begin
        n_fail++; $display("FAIL dvld_out dut%0d: got %b exp %b", k, v[k], sz[k] != 0);
      end
      if (sz[k] != 0) begin
        expv = (k == 0) ? mq0[0] : mq1[0];
        n_chk++;
        if (rec[k] !== expv) begin
          n_fail++; $display("FAIL rec_out dut%0d: got %h exp %h", k, rec[k], expv);
        end
      end
      n_chk++;
      if ({b[k], h[k], m[k], e[k]} !== {m_blk[k], m_hit[k], m_miss[k], m_err[k]}) begin
        n_fail++;
        $display("FAIL stats dut%0d: got blk=%0d hit=%0d miss=%0d err=%b exp %0d %0d %0d %b",
                 k, b[k], h[k], m[k], e[k], m_blk[k], m_hit[k], m_miss[k], m_err[k]);
      end
    end
    @(posedge clk);
    dv[0] = dv0; dv[1] = dv1;
    hitb = (data[31:0] != 0);
    bad  = (bvld != 32'hFFFF_FFFF) || !endb || (data[255:96] != 0);
    for (int k = 0; k < 2; k++) begin
      acc[k] = dv[k] && (sz[k] < DEPTH);
      if (sz[k] != 0 && rdy_in) begin
        if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
      end
      if (acc[k]) begin
        if (endb) m_blk[k]++;
        if (hitb) m_hit[k]++; else m_miss[k]++;
        if (bad) m_err[k] = 1'b1;
        if (hitb || k == 1) begin
          if (k == 0) mq0.push_back({cmd, id, data[63:32], data[95:64], m_seq[k]});
          else        mq1.push_back({cmd, id, data[63:32], data[95:64], m_seq[k]});
          m_seq[k]++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; dv0 = 1'b0; dv1 = 1'b0; rdy_in = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; dv0 = 1'b0; dv1 = 1'b0; rdy_in = 1'b1;
    model_clear();
    #1;
    n_chk++;
    if ({ifa.clt_rdy_scn, ifa.clt_dvld_out, blk0, hit0, miss0, err0} !== '0) begin
      n_fail++; $display("FAIL reset_state: rdy=%b dvld=%b blk=%0d hit=%0d miss=%0d err=%b exp all 0",
        ifa.clt_rdy_scn, ifa.clt_dvld_out, blk0, hit0, miss0, err0);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_hit();
    do_reset();
    cmd = 8'h02; id = 24'h000005; data = '0;
    data[31:0] = 32'd1; data[63:32] = 32'h1234; data[95:64] = 32'h3C;
    bvld = 32'hFFFF_FFFF; endb = 1'b1; dv0 = 1'b1; rdy_in = 1'b1;
    step();
    dv0 = 1'b0;
    #1;
    n_chk++;
    if (ifa.clt_dvld_out !== 1'b1 ||
        ifa.clt_rec_out !== 128'h02_000005_00001234_0000003C_00000000) begin
      n_fail++; $display("FAIL single_hit_rec: got v=%b %h", ifa.clt_dvld_out, ifa.clt_rec_out);
    end
    n_chk++;
    if ({blk0, hit0, miss0} !== {32'd1, 32'd1, 32'd0}) begin
      n_fail++; $display("FAIL single_hit_cnt: got %0d %0d %0d exp 1 1 0", blk0, hit0, miss0);
    end
    step();
  endtask

  task automatic test_miss_filter();
    do_reset();
    dv0 = 1'b1; dv1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_beat(1'b0);
      step();
    end
    dv0 = 1'b0; dv1 = 1'b0;
    #1;
    n_chk++;
    if (ifa.clt_dvld_out !== 1'b0 || miss0 !== 32'd3 || blk0 !== 32'd3) begin
      n_fail++; $display("FAIL miss_filter: got dvld=%b miss=%0d blk=%0d exp 0 3 3",
                         ifa.clt_dvld_out, miss0, blk0);
    end
    rdy_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (ifb.clt_dvld_out !== 1'b1 || ifb.clt_rec_out[31:0] !== 32'(i)) begin
        n_fail++; $display("FAIL keep_miss_seq: got v=%b seq=%0d exp 1 %0d",
                           ifb.clt_dvld_out, ifb.clt_rec_out[31:0], i);
      end
      step();
    end
    set_beat(1'b1); dv0 = 1'b1; rdy_in = 1'b0;
    step();
    dv0 = 1'b0;
    #1;
    n_chk++;
    if (ifa.clt_rec_out[31:0] !== 32'd0) begin
      n_fail++; $display("FAIL miss_seq_unchanged: got %0d exp 0", ifa.clt_rec_out[31:0]);
    end
    step();
  endtask

  task automatic test_full();
    int sent = 0, got = 0, cyc = 0;
    do_reset();
    set_beat(1'b1); dv0 = 1'b1;
    while ((sent < 20 || got < 20) && cyc < 200) begin
      if (cyc == 20) rdy_in = 1'b1;
      #1;
      if (cyc == 18) begin
        n_chk++;
        if (ifa.clt_rdy_scn !== 1'b0) begin
          n_fail++; $display("FAIL full_rdy: got %b exp 0 after 16 accepts", ifa.clt_rdy_scn);
        end
      end
      if (rdy_in && mq0.size() != 0) begin
        n_chk++;
        if (ifa.clt_rec_out[31:0] !== 32'(got)) begin
          n_fail++; $display("FAIL full_order: got seq %0d exp %0d", ifa.clt_rec_out[31:0], got);
        end
        got++;
      end
      step();
      if (acc[0]) begin
        sent++;
        if (sent < 20) set_beat(1'b1); else dv0 = 1'b0;
      end
      cyc++;
    end
    n_chk++;
    if (sent != 20 || got != 20 || hit0 !== 32'd20) begin
      n_fail++; $display("FAIL full_drain: sent=%0d got=%0d hit=%0d exp 20 20 20", sent, got, hit0);
    end
  endtask

  task automatic test_concurrency();
    int cnt = 0;
    do_reset();
    dv0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_beat(1'b1);
      step();
    end
    rdy_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_beat(1'b1);
      step();
    end
    dv0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (ifa.clt_dvld_out === 1'b1) cnt++;
      step();
    end
    n_chk++;
    if (cnt != 5) begin
      n_fail++; $display("FAIL concurrency_occ: got %0d entries exp 5", cnt);
    end
  endtask

  task automatic test_proto_err();
    for (int kind = 0; kind < 3; kind++) begin
      do_reset();
      rdy_in = 1'b1; dv0 = 1'b1;
      set_beat(1'b1);
      step();
      set_beat(1'b1);
      if (kind == 0) bvld = 32'h0000_FFFF;
      else if (kind == 1) endb = 1'b0;
      else data[200] = 1'b1;
      step();
      #1;
      n_chk++;
      if (err0 !== 1'b1) begin
        n_fail++; $display("FAIL proto_err kind%0d: got %b exp 1", kind, err0);
      end
      for (int i = 0; i < 3; i++) begin
        set_beat(1'b1);
        step();
      end
      dv0 = 1'b0;
      #1;
      n_chk++;
      if (err0 !== 1'b1) begin
        n_fail++; $display("FAIL proto_err_sticky kind%0d: got %b exp 1", kind, err0);
      end
      step();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_beat($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) bvld = $urandom;
      if ($urandom_range(0, 31) == 0) endb = 1'b0;
      dv0 = $urandom_range(0, 3) != 0;
      dv1 = $urandom_range(0, 3) != 0;
      rdy_in = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step();
    end
    dv0 = 1'b0; dv1 = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    dv0 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_beat(1'b1);
      step();
    end
    dv0 = 1'b0;
    rdy_in = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({ifa.clt_dvld_out, ifa.clt_rdy_scn, blk0, hit0, miss0, err0} !== '0) begin
      n_fail++; $display("FAIL async_reset: dvld=%b rdy=%b blk=%0d hit=%0d miss=%0d err=%b exp all 0",
        ifa.clt_dvld_out, ifa.clt_rdy_scn, blk0, hit0, miss0, err0);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_chk++;
    if (ifa.clt_rdy_scn !== 1'b1 || ifa.clt_dvld_out !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_release: rdy=%b dvld=%b exp 1 0",
                         ifa.clt_rdy_scn, ifa.clt_dvld_out);
    end
    step();
    step();
  endtask

  initial begin
    reset = 1'b1; dv0 = 1'b0; dv1 = 1'b0; rdy_in = 1'b0;
    cmd = '0; id = '0; data = '0; bvld = 32'hFFFF_FFFF; endb = 1'b1;
    model_clear();
    test_reset();
    test_single_hit();
    test_miss_filter();
    test_full();
    test_concurrency();
    test_proto_err();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
